sap_ring_sequencer: RTL and testbench

//  Timing and decode front-end for the SAP control matrix. Generates the one-hot
//  T-state ring T1..T6 and latches the instruction opcode from the IR at the end of T3.

---
 rtl/sap_pkg.sv | 23 ++
 rtl/sap_ring_counter.sv | 32 +++
 rtl/sap_ring_sequencer.sv | 132 +++++++++++++
 tb/tb_sap_ring_sequencer.sv | 177 +++++++++++++++++
 4 files changed

// File: rtl/sap_pkg.sv
// Shared constants for the SAP timing/decode front-end: opcodes, FSM encoding, ring width.
package sap_pkg;

  localparam int T_W = 6;

  localparam logic [3:0] OP_LDA = 4'h0;
  localparam logic [3:0] OP_ADD = 4'h1;
  localparam logic [3:0] OP_SUB = 4'h2;
  localparam logic [3:0] OP_OUT = 4'hE;
  localparam logic [3:0] OP_HLT = 4'hF;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RING = 2'd1;
  localparam logic [1:0] ST_HALT = 2'd2;

  typedef struct packed {
    logic out_s;
    logic sub_s;
    logic add_s;
    logic lda_s;
  } strobe_t;

endpackage

// File: rtl/sap_ring_counter.sv
// One-hot T-state shift register; load_t1 beats clear beats advance.
module sap_ring_counter
  import sap_pkg::*;
(
  input  logic           clk,
  input  logic           load_t1,
  input  logic           clear,
  input  logic           advance,
  output logic [T_W-1:0] t
);

  logic [T_W-1:0] t_d;
  logic [T_W-1:0] t_q;

  always_comb begin
    t_d = t_q;
    if (load_t1) begin
      t_d = T_W'(1);
    end else if (clear) begin
      t_d = '0;
    end else if (advance) begin
      t_d = {t_q[T_W-2:0], t_q[T_W-1]};
    end
  end

  always_ff @(posedge clk) begin
    t_q <= t_d;
  end

  assign t = t_q;

endmodule

// File: rtl/sap_ring_sequencer.sv
// SAP timing front-end: T1..T6 ring, opcode latch at the T3 edge, HLT and run/step control.
// Strobes become visible during T4; every output comes straight from a flop.
module sap_ring_sequencer
  import sap_pkg::*;
#(
  parameter int OPCODE_W = 4,
  parameter int CNT_W    = 8
) (
  input  logic                clk,
  input  logic                clr,
  input  logic                run,
  input  logic                step,
  input  logic [OPCODE_W-1:0] ir_opcode,
  output logic [T_W-1:0]      t,
  output logic                lda,
  output logic                add,
  output logic                sub,
  output logic                out,
  output logic                halted,
  output logic                illegal,
  output logic [CNT_W-1:0]    instr_count
);

  logic [1:0]       state_d, state_q;
  strobe_t          strobe_d, strobe_q;
  logic             illegal_d, illegal_q;
  logic [CNT_W-1:0] count_d, count_q;

  strobe_t dec_strobe;
  logic    dec_legal;
  logic    dec_hlt;
  logic    load_t1, ring_clear, advance;

  sap_ring_counter u_ring (
    .clk     (clk),
    .load_t1 (load_t1),
    .clear   (ring_clear),
    .advance (advance),
    .t       (t)
  );

  always_comb begin
    dec_strobe = '0;
    dec_legal  = 1'b1;
    dec_hlt    = 1'b0;
    case (ir_opcode)
      OPCODE_W'(OP_LDA): dec_strobe.lda_s = 1'b1;
      OPCODE_W'(OP_ADD): dec_strobe.add_s = 1'b1;
      OPCODE_W'(OP_SUB): dec_strobe.sub_s = 1'b1;
      OPCODE_W'(OP_OUT): dec_strobe.out_s = 1'b1;
      OPCODE_W'(OP_HLT): dec_hlt          = 1'b1;
      default:           dec_legal        = 1'b0;
    endcase
  end

  always_comb begin
    state_d    = state_q;
    strobe_d   = strobe_q;
    illegal_d  = illegal_q;
    count_d    = count_q;
    load_t1    = 1'b0;
    ring_clear = 1'b0;
    advance    = 1'b0;
    if (clr) begin
      // Reset lands directly in T1 when free-running so no idle cycle is lost.
      load_t1    = run;
      ring_clear = ~run;
    end else begin
      case (state_q)
        ST_IDLE: begin
          ring_clear = 1'b1;
          if (run || step) begin
            state_d = ST_RING;
            load_t1 = 1'b1;
          end
        end
        ST_RING: begin
          if (t[2]) begin
            if (dec_hlt) begin
              state_d    = ST_HALT;
              ring_clear = 1'b1;
              strobe_d   = '0;
            end else begin
              advance   = 1'b1;
              strobe_d  = dec_strobe;
              illegal_d = illegal_q | ~dec_legal;
            end
          end else if (t[T_W-1]) begin
            count_d  = count_q + CNT_W'(1);
            strobe_d = '0;
            if (run) begin
              load_t1 = 1'b1;
            end else begin
              ring_clear = 1'b1;
              state_d    = ST_IDLE;
            end
          end else begin
            advance = 1'b1;
          end
        end
        ST_HALT: ring_clear = 1'b1;
        default: begin
          state_d    = ST_IDLE;
          ring_clear = 1'b1;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      state_q   <= run ? ST_RING : ST_IDLE;
      strobe_q  <= '0;
      illegal_q <= 1'b0;
      count_q   <= '0;
    end else begin
      state_q   <= state_d;
      strobe_q  <= strobe_d;
      illegal_q <= illegal_d;
      count_q   <= count_d;
    end
  end

  assign lda         = strobe_q.lda_s;
  assign add         = strobe_q.add_s;
  assign sub         = strobe_q.sub_s;
  assign out         = strobe_q.out_s;
  assign halted      = (state_q == ST_HALT);
  assign illegal     = illegal_q;
  assign instr_count = count_q;

endmodule

// File: tb/tb_sap_ring_sequencer.sv
// Directed bench for sap_ring_sequencer: reset, decode, single-step, HLT, illegal, wrap.
module tb_sap_ring_sequencer;

  logic       clk = 1'b0;
  logic       clr = 1'b1;
  logic       run = 1'b1;
  logic       step = 1'b0;
  logic [3:0] ir_opcode = 4'h0;
  logic [5:0] t;
  logic       lda, add, sub, out, halted, illegal;
  logic [7:0] instr_count;

  int checks = 0;
  int passed = 0;

  sap_ring_sequencer #(.OPCODE_W(4), .CNT_W(8)) dut (
    .clk         (clk),
    .clr         (clr),
    .run         (run),
    .step        (step),
    .ir_opcode   (ir_opcode),
    .t           (t),
    .lda         (lda),
    .add         (add),
    .sub         (sub),
    .out         (out),
    .halted      (halted),
    .illegal     (illegal),
    .instr_count (instr_count)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_clr(input logic run_v);
    clr = 1'b1;
    run = run_v;
    tick();
    tick();
    clr = 1'b0;
  endtask

  task automatic test_reset();
    step = 1'b0;
    do_clr(1'b1);
    checks++; if (t !== 6'h01) $display("FAIL reset_t: got %h want 01", t); else passed++;
    checks++; if (instr_count !== 8'd0) $display("FAIL reset_count: got %0d want 0", instr_count); else passed++;
    checks++; if (illegal !== 1'b0) $display("FAIL reset_illegal: got %b want 0", illegal); else passed++;
    checks++; if (halted !== 1'b0) $display("FAIL reset_halted: got %b want 0", halted); else passed++;
    checks++; if ({out, sub, add, lda} !== 4'b0000) $display("FAIL reset_strobes: got %b want 0000", {out, sub, add, lda}); else passed++;
  endtask

  task automatic test_add();
    logic [5:0] exp_t;
    logic [3:0] exp_s;
    logic [7:0] exp_c;
    ir_opcode = 4'h1;
    for (int i = 0; i < 7; i++) begin
      exp_t = (i == 6) ? 6'h01 : (6'h01 << i);
      exp_s = (i >= 3 && i <= 5) ? 4'b0010 : 4'b0000;
      exp_c = (i == 6) ? 8'd1 : 8'd0;
      checks++; if (t !== exp_t) $display("FAIL add_t[%0d]: got %h want %h", i, t, exp_t); else passed++;
      checks++; if ({out, sub, add, lda} !== exp_s) $display("FAIL add_strobes[%0d]: got %b want %b", i, {out, sub, add, lda}, exp_s); else passed++;
      checks++; if (instr_count !== exp_c) $display("FAIL add_count[%0d]: got %0d want %0d", i, instr_count, exp_c); else passed++;
      if (i < 6) tick();
    end
  endtask

  task automatic test_step();
    logic [5:0] exp_t;
    logic [3:0] exp_s;
    do_clr(1'b0);
    ir_opcode = 4'h0;
    checks++; if (t !== 6'h00) $display("FAIL step_idle_t: got %h want 00", t); else passed++;
    tick(); tick(); tick();
    checks++; if (t !== 6'h00) $display("FAIL step_idle_hold: got %h want 00", t); else passed++;
    step = 1'b1;
    tick();
    step = 1'b0;
    for (int i = 0; i < 7; i++) begin
      exp_t = (i == 6) ? 6'h00 : (6'h01 << i);
      exp_s = (i >= 3 && i <= 5) ? 4'b0001 : 4'b0000;
      checks++; if (t !== exp_t) $display("FAIL step_t[%0d]: got %h want %h", i, t, exp_t); else passed++;
      checks++; if ({out, sub, add, lda} !== exp_s) $display("FAIL step_strobes[%0d]: got %b want %b", i, {out, sub, add, lda}, exp_s); else passed++;
      if (i < 6) tick();
    end
    tick(); tick(); tick();
    checks++; if (t !== 6'h00) $display("FAIL step_after_t: got %h want 00", t); else passed++;
    checks++; if (instr_count !== 8'd1) $display("FAIL step_count: got %0d want 1", instr_count); else passed++;
    // Held step: one instruction per 7 cycles.
    step = 1'b1;
    for (int i = 0; i < 14; i++) tick();
    step = 1'b0;
    checks++; if (instr_count !== 8'd3) $display("FAIL step_held_count: got %0d want 3", instr_count); else passed++;
    checks++; if (t !== 6'h00) $display("FAIL step_held_t: got %h want 00", t); else passed++;
  endtask

  task automatic test_halt();
    do_clr(1'b1);
    ir_opcode = 4'hF;
    tick(); tick();
    checks++; if (t !== 6'h04 || halted !== 1'b0) $display("FAIL halt_pre: got t=%h halted=%b want t=04 halted=0", t, halted); else passed++;
    tick();
    checks++; if (t !== 6'h00 || halted !== 1'b1) $display("FAIL halt_enter: got t=%h halted=%b want t=00 halted=1", t, halted); else passed++;
    checks++; if ({out, sub, add, lda} !== 4'b0000) $display("FAIL halt_strobes: got %b want 0000", {out, sub, add, lda}); else passed++;
    for (int i = 0; i < 20; i++) begin
      run  = i[0];
      step = i[1];
      tick();
      checks++;
      if (t !== 6'h00 || halted !== 1'b1 || instr_count !== 8'd0)
        $display("FAIL halt_hold[%0d]: got t=%h halted=%b count=%0d want t=00 halted=1 count=0", i, t, halted, instr_count);
      else passed++;
    end
    step = 1'b0;
    ir_opcode = 4'h0;
    do_clr(1'b1);
    checks++; if (t !== 6'h01 || halted !== 1'b0) $display("FAIL halt_recover: got t=%h halted=%b want t=01 halted=0", t, halted); else passed++;
  endtask

  task automatic test_illegal();
    logic [3:0] ops [3];
    logic [3:0] exp_s [3];
    ops[0] = 4'h5; exp_s[0] = 4'b0000;
    ops[1] = 4'hE; exp_s[1] = 4'b1000;
    ops[2] = 4'h2; exp_s[2] = 4'b0100;
    do_clr(1'b1);
    for (int k = 0; k < 3; k++) begin
      ir_opcode = ops[k];
      tick(); tick(); tick();
      checks++; if (t !== 6'h08) $display("FAIL ill_t[%0d]: got %h want 08", k, t); else passed++;
      checks++; if ({out, sub, add, lda} !== exp_s[k]) $display("FAIL ill_strobes[%0d]: got %b want %b", k, {out, sub, add, lda}, exp_s[k]); else passed++;
      checks++; if (illegal !== 1'b1) $display("FAIL ill_flag[%0d]: got %b want 1", k, illegal); else passed++;
      tick(); tick();
      checks++; if ({out, sub, add, lda} !== exp_s[k]) $display("FAIL ill_strobes_t6[%0d]: got %b want %b", k, {out, sub, add, lda}, exp_s[k]); else passed++;
      tick();
    end
    checks++; if (instr_count !== 8'd3) $display("FAIL ill_count: got %0d want 3", instr_count); else passed++;
    do_clr(1'b1);
    checks++; if (illegal !== 1'b0) $display("FAIL ill_clr: got %b want 0", illegal); else passed++;
  endtask

  task automatic test_wrap();
    do_clr(1'b1);
    ir_opcode = 4'h0;
    for (int i = 0; i < 255 * 6; i++) tick();
    checks++; if (instr_count !== 8'd255) $display("FAIL wrap_255: got %0d want 255", instr_count); else passed++;
    for (int i = 0; i < 6; i++) tick();
    checks++; if (instr_count !== 8'd0 || t !== 6'h01) $display("FAIL wrap_0: got count=%0d t=%h want count=0 t=01", instr_count, t); else passed++;
    for (int i = 0; i < 6; i++) tick();
    checks++; if (instr_count !== 8'd1) $display("FAIL wrap_next: got %0d want 1", instr_count); else passed++;
    tick(); tick(); tick(); tick();
    checks++; if (t !== 6'h10 || lda !== 1'b1) $display("FAIL abort_pre: got t=%h lda=%b want t=10 lda=1", t, lda); else passed++;
    clr = 1'b1;
    tick();
    clr = 1'b0;
    checks++; if (t !== 6'h01 || instr_count !== 8'd0 || lda !== 1'b0)
      $display("FAIL abort_post: got t=%h count=%0d lda=%b want t=01 count=0 lda=0", t, instr_count, lda);
    else passed++;
  endtask

  initial begin
    test_reset();
    test_add();
    test_step();
    test_halt();
    test_illegal();
    test_wrap();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
